// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared constants and state encoding for the 9-bit processor control unit
package proc_pkg;

    localparam int DATA_W = 9;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

endpackage

// File: rtl/dec3to8.sv
// rtl/dec3to8.sv - 3-bit to 8-bit one-hot decoder with enable
module dec3to8 (
    input  logic [2:0] w,
    input  logic       en,
    output logic [7:0] y
);

    assign y = en ? (8'b0000_0001 << w) : 8'b0;

endmodule

// File: rtl/proc_ctrl.sv
// rtl/proc_ctrl.sv - instruction step sequencer driving bus selects, load enables and ALU control
module proc_ctrl
    import proc_pkg::*;
(
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic [7:0]        Rout,
    output logic              Gout,
    output logic              DINout,
    output logic [7:0]        Rin,
    output logic              Ain,
    output logic              Gin,
    output logic              AddSub,
    output logic              Done,
    output logic              Busy
);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] ir;
    logic [7:0]        x_onehot;
    logic [7:0]        y_onehot;
    logic [2:0]        opcode;
    logic              is_arith;

    assign opcode   = ir[8:6];
    assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);

    dec3to8 u_dec_x (.w(ir[5:3]), .en(1'b1), .y(x_onehot));
    dec3to8 u_dec_y (.w(ir[2:0]), .en(1'b1), .y(y_onehot));

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == T0 && Run) begin
                ir <= DIN;
            end
        end
    end

    always_comb begin
        state_next = state;
        Rout       = 8'b0;
        Gout       = 1'b0;
        DINout     = 1'b0;
        Rin        = 8'b0;
        Ain        = 1'b0;
        Gin        = 1'b0;
        AddSub     = 1'b0;
        Done       = 1'b0;
        Busy       = 1'b0;
        case (state)
            T0: begin
                if (Run) begin
                    state_next = T1;
                end
            end
            T1: begin
                Busy = 1'b1;
                case (opcode)
                    OP_MV: begin
                        Rout       = y_onehot;
                        Rin        = x_onehot;
                        Done       = 1'b1;
                        state_next = T0;
                    end
                    OP_MVI: begin
                        DINout     = 1'b1;
                        Rin        = x_onehot;
                        Done       = 1'b1;
                        state_next = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        Rout       = x_onehot;
                        Ain        = 1'b1;
                        state_next = T2;
                    end
                    default: begin
                        Done       = 1'b1;
                        state_next = T0;
                    end
                endcase
            end
            // T2/T3 only make sense for add/sub; anything else falls back to idle silently.
            T2: begin
                state_next = T0;
                if (is_arith) begin
                    Busy       = 1'b1;
                    Rout       = y_onehot;
                    Gin        = 1'b1;
                    AddSub     = (opcode == OP_SUB);
                    state_next = T3;
                end
            end
            T3: begin
                state_next = T0;
                if (is_arith) begin
                    Busy = 1'b1;
                    Gout = 1'b1;
                    Rin  = x_onehot;
                    Done = 1'b1;
                end
            end
            default: state_next = T0;
        endcase
    end

endmodule

// File: tb/tb_proc_ctrl.sv
// tb/tb_proc_ctrl.sv - scoreboard bench for proc_ctrl with randomized instruction stream
module tb_proc_ctrl;
    import proc_pkg::*;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       Run = 1'b0;
    logic [8:0] DIN = 9'd0;
    logic [7:0] Rout, Rin;
    logic       Gout, DINout, Ain, Gin, AddSub, Done, Busy;

    int checks = 0;
    int failures = 0;

    // {Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done, Busy}
    logic [22:0] exp_q[$];

    proc_ctrl dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN),
        .Rout(Rout), .Gout(Gout), .DINout(DINout), .Rin(Rin),
        .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .Done(Done), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    function automatic logic [22:0] pk(input logic [7:0] rout, input logic gout, input logic dinout,
                                       input logic [7:0] rin, input logic ain, input logic gin,
                                       input logic addsub, input logic done, input logic busy);
        return {rout, gout, dinout, rin, ain, gin, addsub, done, busy};
    endfunction

    function automatic logic [22:0] actual();
        return {Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done, Busy};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    // Monitor: every busy cycle must match the next queued step; idle cycles must be fully quiet.
    initial begin
        logic [22:0] act;
        logic [22:0] want;
        forever begin
            @(negedge Clock);
            act = actual();
            check("bus_exclusive", 32'($countones({Rout, Gout, DINout}) <= 1), 32'd1);
            check("rin_onehot0", 32'($onehot0(Rin)), 32'd1);
            if (act[0]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_busy_step", {9'd0, act}, 32'd0);
                end else begin
                    want = exp_q.pop_front();
                    check("step_outputs", {9'd0, act}, {9'd0, want});
                end
            end else begin
                check("idle_outputs", {9'd0, act}, 32'd0);
            end
        end
    end

    // Caller enters #1 after a posedge with the DUT in T0; returns in the same phase, DUT back in T0.
    task automatic issue(input logic [8:0] ir, input logic [8:0] imm, input bit toggle_run);
        logic [2:0] op;
        logic [7:0] xo, yo;
        int steps;
        op = ir[8:6];
        xo = 8'd1 << ir[5:3];
        yo = 8'd1 << ir[2:0];
        Run = 1'b1;
        DIN = ir;
        case (op)
            3'd0: begin exp_q.push_back(pk(yo, 0, 0, xo, 0, 0, 0, 1, 1)); steps = 1; end
            3'd1: begin exp_q.push_back(pk(0, 0, 1, xo, 0, 0, 0, 1, 1)); steps = 1; end
            3'd2, 3'd3: begin
                exp_q.push_back(pk(xo, 0, 0, 0, 1, 0, 0, 0, 1));
                exp_q.push_back(pk(yo, 0, 0, 0, 0, 1, op == 3'd3, 0, 1));
                exp_q.push_back(pk(0, 1, 0, xo, 0, 0, 0, 1, 1));
                steps = 3;
            end
            default: begin exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 1, 1)); steps = 1; end
        endcase
        for (int k = 1; k <= steps + 1; k++) begin
            @(posedge Clock);
            #1;
            if (k <= steps) begin
                DIN = (k == 1) ? imm : 9'($urandom_range(0, 511));
                Run = toggle_run ? 1'($urandom_range(0, 1)) : 1'b1;
            end else begin
                Run = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        Run = 1'b0;
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    initial begin
        logic [8:0] r_ir;
        #2;
        check("reset_outputs", {9'd0, actual()}, 32'd0);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        idle(2);

        issue(9'b001_000_000, 9'd5, 1'b0);
        issue(9'b000_001_000, 9'd0, 1'b0);
        issue(9'b010_000_001, 9'd0, 1'b1);
        issue(9'b011_111_010, 9'd0, 1'b0);
        issue(9'b011_111_010, 9'd0, 1'b1);
        issue(9'b101_110_011, 9'd0, 1'b1);
        issue(9'b000_100_100, 9'd0, 1'b0);
        idle(2);

        // Abort an add in the middle of T2.
        Run = 1'b1;
        DIN = 9'b010_011_100;
        exp_q.push_back(pk(8'h08, 0, 0, 0, 1, 0, 0, 0, 1));
        @(posedge Clock);
        #1;
        Run = 1'b0;
        @(posedge Clock);
        #2;
        Resetn = 1'b0;
        #1;
        check("abort_outputs", {9'd0, actual()}, 32'd0);
        check("abort_state", 32'(dut.state), 32'(T0));
        check("abort_ir", 32'(dut.ir), 32'd0);
        @(posedge Clock);
        #3;
        Resetn = 1'b1;
        @(posedge Clock);
        #1;
        idle(3);
        check("abort_state_after", 32'(dut.state), 32'(T0));
        check("abort_queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        for (int i = 0; i < 60; i++) begin
            r_ir = 9'($urandom_range(0, 511));
            issue(r_ir, 9'($urandom_range(0, 511)), 1'b1);
            if ($urandom_range(0, 3) == 0) idle(32'($urandom_range(1, 3)));
        end
        idle(4);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
